// File: rtl/width_adapter_arbiter.sv
// rtl/width_adapter_arbiter.sv - packet-level round-robin arbiter feeding one width adapter
module width_adapter_arbiter #(
    parameter int N         = 4,
    parameter int IW        = 64,
    parameter int TIMEOUT   = 255,
    parameter int FLUSH_EOP = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N*IW-1:0]               req_data,
    input  logic [N-1:0]                  req_valid,
    input  logic [N-1:0]                  req_last,
    output logic [N-1:0]                  req_ready,
    output logic [IW-1:0]                 ad_idata,
    output logic                          ad_ivalid,
    input  logic                          ad_iready,
    output logic                          ad_flush,
    output logic                          grant_valid,
    output logic [(N>1?$clog2(N):1)-1:0]  grant_id,
    output logic                          abort
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [CW-1:0] idle_q, idle_d;

    logic          found;
    logic [GW-1:0] winner;
    logic          g_valid;
    logic          g_last;
    logic [IW-1:0] g_data;
    logic          fire;
    logic          timeout_hit;

    // Rotating priority: requesters above last_grant first, then wrap to the low ones.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int c = 0; c < N; c++) begin
            if (!found && req_valid[c] && (GW'(c) > last_q)) begin
                found  = 1'b1;
                winner = GW'(c);
            end
        end
        for (int c = 0; c < N; c++) begin
            if (!found && req_valid[c] && (GW'(c) <= last_q)) begin
                found  = 1'b1;
                winner = GW'(c);
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == GW'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*IW +: IW];
            end
        end
    end

    assign fire        = (state_q == S_STREAM) && g_valid && ad_iready;
    assign timeout_hit = (TIMEOUT != 0) && (state_q == S_STREAM) && !g_valid && (idle_q == TMAX);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        idle_d      = idle_q;
        req_ready   = '0;
        ad_idata    = g_data;
        ad_ivalid   = 1'b0;
        ad_flush    = 1'b0;
        grant_valid = 1'b0;
        abort       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    last_d  = winner;
                    idle_d  = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                grant_valid = 1'b1;
                ad_ivalid   = g_valid;
                for (int i = 0; i < N; i++) begin
                    if (grant_q == GW'(i)) begin
                        req_ready[i] = ad_iready;
                    end
                end
                if (fire) begin
                    idle_d = '0;
                    if (g_last) begin
                        state_d = (FLUSH_EOP != 0) ? S_FLUSH : S_IDLE;
                    end
                end else if (!g_valid) begin
                    // A stalled-by-backpressure beat is not idle, so only count missing valid.
                    if (timeout_hit) begin
                        abort   = 1'b1;
                        state_d = S_FLUSH;
                    end else if (idle_q != TMAX) begin
                        idle_d = idle_q + CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                ad_flush = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= GW'(N - 1);
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            idle_q  <= idle_d;
        end
    end

    assign grant_id = grant_q;

endmodule
